// File: rtl/id_ex_alu_issue.sv
// ---------------------------------------------------------------------------
// id_ex_alu_issue
//
// ID/EX pipeline register for a MIPS32 core. It captures the decoded ID-stage
// fields, turns ALUOp/funct into the 4-bit ALU control code, and presents the
// EX-stage operands (Read_Data_1_EX, ALU_Data_2_EX, Read_Data_2_EX) to the ALU.
// It also detects RAW hazards against the instruction in EX (and, without
// forwarding, the one in MEM) and inserts bubbles.
//
// Build option:
//   FORWARDING_EN  defined   : MEM/WB forwarding muxes on the EX operands;
//                              only load-use hazards stall.
//                  undefined : operands come straight from the EX registers;
//                              any RAW hazard against EX or MEM stalls (WB is
//                              covered by the write-first register file).
//
// Ports:
//   Clk, Reset          clock (rising edge), async active-high reset
//   Stall_EX            hold the EX register (has priority over bubbles)
//   Flush_ID            turn the instruction entering EX into a bubble
//   Valid_ID            ID holds a real instruction
//   *_ID                register data, immediate, funct, rs/rt/rd, controls
//   *_MEM, *_WB         downstream destinations/enables/forwarding data
//   Read_Data_1_EX      ALU operand A
//   ALU_Data_2_EX       ALU operand B (immediate or rt value)
//   Read_Data_2_EX      rt value (store data)
//   ALU_Control_EX      add 0010, sub 0110, and 0000, or 0001, slt 0111,
//                       invalid 1111
//   Write_Register_EX   resolved destination register
//   RegWrite_EX, MemRead_EX, Valid_EX   registered control
//   Load_Use_Stall      combinational; holds PC and IF/ID
//
// Handshake: there is no valid/ready pair here. Valid_ID qualifies the ID
// fields; Stall_EX freezes the whole EX register; Load_Use_Stall asks the
// front end to hold while a bubble is written into EX.
// ---------------------------------------------------------------------------
module id_ex_alu_issue #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Stall_EX,
    input  logic               Flush_ID,
    input  logic               Valid_ID,
    input  logic [WIDTH-1:0]   Read_Data_1_ID,
    input  logic [WIDTH-1:0]   Read_Data_2_ID,
    input  logic [15:0]        Imm_ID,
    input  logic [5:0]         Funct_ID,
    input  logic [REGADDR-1:0] Rs_ID,
    input  logic [REGADDR-1:0] Rt_ID,
    input  logic [REGADDR-1:0] Rd_ID,
    input  logic [1:0]         ALUOp_ID,
    input  logic               ALUSrc_ID,
    input  logic               RegDst_ID,
    input  logic               RegWrite_ID,
    input  logic               MemRead_ID,
    input  logic [REGADDR-1:0] Write_Register_MEM,
    input  logic [REGADDR-1:0] Write_Register_WB,
    input  logic               RegWrite_MEM,
    input  logic               RegWrite_WB,
    input  logic [WIDTH-1:0]   ALU_Result_MEM,
    input  logic [WIDTH-1:0]   Write_Data_WB,
    output logic [WIDTH-1:0]   Read_Data_1_EX,
    output logic [WIDTH-1:0]   ALU_Data_2_EX,
    output logic [WIDTH-1:0]   Read_Data_2_EX,
    output logic [3:0]         ALU_Control_EX,
    output logic [REGADDR-1:0] Write_Register_EX,
    output logic               RegWrite_EX,
    output logic               MemRead_EX,
    output logic               Valid_EX,
    output logic               Load_Use_Stall
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    // Registered EX fields that are not ports
    logic [WIDTH-1:0]   rd1_ex;
    logic [WIDTH-1:0]   rd2_ex;
    logic [WIDTH-1:0]   imm_ex;
    logic [REGADDR-1:0] rs_ex;
    logic [REGADDR-1:0] rt_ex;
    logic               alusrc_ex;

    logic [WIDTH-1:0]   imm_ext_id;
    logic [3:0]         alu_control_id;
    logic               hazard;
    logic [WIDTH-1:0]   fwd_rt;

    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] code;
        case (op)
            2'b00:   code = ALU_ADD;
            2'b01:   code = ALU_SUB;
            2'b11:   code = ALU_OR;
            default: begin
                case (funct)
                    6'b100000: code = ALU_ADD;
                    6'b100010: code = ALU_SUB;
                    6'b100100: code = ALU_AND;
                    6'b100101: code = ALU_OR;
                    6'b101010: code = ALU_SLT;
                    default:   code = ALU_BAD;
                endcase
            end
        endcase
        return code;
    endfunction

    // ori zero-extends its immediate; everything else sign-extends
    assign imm_ext_id = (ALUOp_ID == 2'b11) ? {{(WIDTH-16){1'b0}}, Imm_ID}
                                            : {{(WIDTH-16){Imm_ID[15]}}, Imm_ID};
    assign alu_control_id = alu_decode(ALUOp_ID, Funct_ID);

`ifdef FORWARDING_EN
    // Only a load in EX cannot be covered by forwarding
    assign hazard = Valid_EX && MemRead_EX && Valid_ID && (Write_Register_EX != '0) &&
                    ((Write_Register_EX == Rs_ID) || (Write_Register_EX == Rt_ID));
`else
    function automatic logic raw_hit(input logic [REGADDR-1:0] src);
        return (src != '0) &&
               ((RegWrite_EX && Valid_EX && (src == Write_Register_EX)) ||
                (RegWrite_MEM && (src == Write_Register_MEM)));
    endfunction

    assign hazard = Valid_ID && (raw_hit(Rs_ID) || raw_hit(Rt_ID));
`endif

    // A flushed instruction never needs to wait; reset drops the request at once
    assign Load_Use_Stall = hazard && !Flush_ID && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd1_ex            <= '0;
            rd2_ex            <= '0;
            imm_ex            <= '0;
            rs_ex             <= '0;
            rt_ex             <= '0;
            alusrc_ex         <= 1'b0;
            ALU_Control_EX    <= ALU_ADD;
            Write_Register_EX <= '0;
            RegWrite_EX       <= 1'b0;
            MemRead_EX        <= 1'b0;
            Valid_EX          <= 1'b0;
        end else if (Stall_EX) begin
            // hold everything; a pending bubble waits for the first free edge
        end else if (Flush_ID || Load_Use_Stall) begin
            rd1_ex            <= '0;
            rd2_ex            <= '0;
            imm_ex            <= '0;
            rs_ex             <= '0;
            rt_ex             <= '0;
            alusrc_ex         <= 1'b0;
            ALU_Control_EX    <= ALU_ADD;
            Write_Register_EX <= '0;
            RegWrite_EX       <= 1'b0;
            MemRead_EX        <= 1'b0;
            Valid_EX          <= 1'b0;
        end else begin
            rd1_ex            <= Read_Data_1_ID;
            rd2_ex            <= Read_Data_2_ID;
            imm_ex            <= imm_ext_id;
            rs_ex             <= Rs_ID;
            rt_ex             <= Rt_ID;
            alusrc_ex         <= ALUSrc_ID;
            ALU_Control_EX    <= alu_control_id;
            Write_Register_EX <= RegDst_ID ? Rd_ID : Rt_ID;
            // side effects only for a real instruction
            RegWrite_EX       <= RegWrite_ID && Valid_ID;
            MemRead_EX        <= MemRead_ID && Valid_ID;
            Valid_EX          <= Valid_ID;
        end
    end

`ifdef FORWARDING_EN
    // MEM is the younger producer, so it beats WB; $0 is never forwarded
    always_comb begin
        Read_Data_1_EX = rd1_ex;
        if (RegWrite_MEM && (Write_Register_MEM != '0) && (Write_Register_MEM == rs_ex))
            Read_Data_1_EX = ALU_Result_MEM;
        else if (RegWrite_WB && (Write_Register_WB != '0) && (Write_Register_WB == rs_ex))
            Read_Data_1_EX = Write_Data_WB;
    end

    always_comb begin
        fwd_rt = rd2_ex;
        if (RegWrite_MEM && (Write_Register_MEM != '0) && (Write_Register_MEM == rt_ex))
            fwd_rt = ALU_Result_MEM;
        else if (RegWrite_WB && (Write_Register_WB != '0) && (Write_Register_WB == rt_ex))
            fwd_rt = Write_Data_WB;
    end
`else
    assign Read_Data_1_EX = rd1_ex;
    assign fwd_rt         = rd2_ex;

    // Forwarding sources and source tags have no consumer in this build
    logic unused_fwd;
    assign unused_fwd = ^{ALU_Result_MEM, Write_Data_WB, Write_Register_WB,
                          RegWrite_WB, rs_ex, rt_ex};
`endif

    assign Read_Data_2_EX = fwd_rt;
    assign ALU_Data_2_EX  = alusrc_ex ? imm_ex : fwd_rt;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_id_ex_alu_issue
//
// Self-checking bench for id_ex_alu_issue. Expected EX contents are pushed to
// a queue whenever an ID instruction (or bubble/hold) is scheduled and popped
// one cycle later when the EX register is sampled. Expectations follow the
// build option FORWARDING_EN.
// ---------------------------------------------------------------------------
module tb_id_ex_alu_issue;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] alu2;
        logic [31:0] rd2;
        logic [3:0]  ctrl;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        v;
    } exp_t;

    logic        Clk, Reset, Stall_EX, Flush_ID, Valid_ID;
    logic [31:0] Read_Data_1_ID, Read_Data_2_ID;
    logic [15:0] Imm_ID;
    logic [5:0]  Funct_ID;
    logic [4:0]  Rs_ID, Rt_ID, Rd_ID;
    logic [1:0]  ALUOp_ID;
    logic        ALUSrc_ID, RegDst_ID, RegWrite_ID, MemRead_ID;
    logic [4:0]  Write_Register_MEM, Write_Register_WB;
    logic        RegWrite_MEM, RegWrite_WB;
    logic [31:0] ALU_Result_MEM, Write_Data_WB;
    logic [31:0] Read_Data_1_EX, ALU_Data_2_EX, Read_Data_2_EX;
    logic [3:0]  ALU_Control_EX;
    logic [4:0]  Write_Register_EX;
    logic        RegWrite_EX, MemRead_EX, Valid_EX, Load_Use_Stall;

    logic [$bits(exp_t)-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [5:0] funct_tbl [0:4];

    id_ex_alu_issue dut (
        .Clk(Clk), .Reset(Reset), .Stall_EX(Stall_EX), .Flush_ID(Flush_ID),
        .Valid_ID(Valid_ID), .Read_Data_1_ID(Read_Data_1_ID),
        .Read_Data_2_ID(Read_Data_2_ID), .Imm_ID(Imm_ID), .Funct_ID(Funct_ID),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID), .ALUOp_ID(ALUOp_ID),
        .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID), .RegWrite_ID(RegWrite_ID),
        .MemRead_ID(MemRead_ID), .Write_Register_MEM(Write_Register_MEM),
        .Write_Register_WB(Write_Register_WB), .RegWrite_MEM(RegWrite_MEM),
        .RegWrite_WB(RegWrite_WB), .ALU_Result_MEM(ALU_Result_MEM),
        .Write_Data_WB(Write_Data_WB), .Read_Data_1_EX(Read_Data_1_EX),
        .ALU_Data_2_EX(ALU_Data_2_EX), .Read_Data_2_EX(Read_Data_2_EX),
        .ALU_Control_EX(ALU_Control_EX), .Write_Register_EX(Write_Register_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Valid_EX(Valid_EX),
        .Load_Use_Stall(Load_Use_Stall)
    );

    // ---- clock / reset ----
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---- checking ----
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---- reference model of one issued instruction ----
    function automatic exp_t model(input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [31:0] d1, input logic [31:0] d2,
                                   input logic [15:0] imm, input logic [5:0] funct,
                                   input logic [1:0] aluop, input logic alusrc,
                                   input logic regdst, input logic regwrite,
                                   input logic memread);
        exp_t e;
        logic [31:0] ext;
        ext = (aluop == 2'b11) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
        case (aluop)
            2'b00: e.ctrl = 4'b0010;
            2'b01: e.ctrl = 4'b0110;
            2'b11: e.ctrl = 4'b0001;
            default: begin
                if      (funct == 6'h20) e.ctrl = 4'b0010;
                else if (funct == 6'h22) e.ctrl = 4'b0110;
                else if (funct == 6'h24) e.ctrl = 4'b0000;
                else if (funct == 6'h25) e.ctrl = 4'b0001;
                else if (funct == 6'h2a) e.ctrl = 4'b0111;
                else                     e.ctrl = 4'b1111;
            end
        endcase
        e.rd1  = d1;
        e.rd2  = d2;
        e.alu2 = alusrc ? ext : d2;
        e.wr   = regdst ? rd : rt;
        e.rw   = regwrite;
        e.mr   = memread;
        e.v    = 1'b1;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e = '0;
        e.ctrl = 4'b0010;
        return e;
    endfunction

    // ---- drivers ----
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [15:0] imm, input logic [5:0] funct,
                          input logic [1:0] aluop, input logic alusrc, input logic regdst,
                          input logic regwrite, input logic memread);
        Valid_ID = 1'b1;
        Rs_ID = rs; Rt_ID = rt; Rd_ID = rd;
        Read_Data_1_ID = d1; Read_Data_2_ID = d2;
        Imm_ID = imm; Funct_ID = funct; ALUOp_ID = aluop;
        ALUSrc_ID = alusrc; RegDst_ID = regdst;
        RegWrite_ID = regwrite; MemRead_ID = memread;
    endtask

    // one clock edge, then compare EX outputs against the oldest expectation
    task automatic tick_check();
        exp_t e;
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_t'(exp_q.pop_front());
            check("rd1",      Read_Data_1_EX, e.rd1);
            check("alu2",     ALU_Data_2_EX, e.alu2);
            check("rd2",      Read_Data_2_EX, e.rd2);
            check("ctrl",     {28'h0, ALU_Control_EX}, {28'h0, e.ctrl});
            check("wr",       {27'h0, Write_Register_EX}, {27'h0, e.wr});
            check("regwrite", {31'h0, RegWrite_EX}, {31'h0, e.rw});
            check("memread",  {31'h0, MemRead_EX}, {31'h0, e.mr});
            check("valid",    {31'h0, Valid_EX}, {31'h0, e.v});
        end
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [15:0] imm, input logic [5:0] funct,
                         input logic [1:0] aluop, input logic alusrc, input logic regdst,
                         input logic regwrite, input logic memread);
        set_id(rs, rt, rd, d1, d2, imm, funct, aluop, alusrc, regdst, regwrite, memread);
        exp_q.push_back(model(rt, rd, d1, d2, imm, funct, aluop, alusrc, regdst,
                              regwrite, memread));
        tick_check();
    endtask

    // lw $9, 0x10($4)
    task automatic issue_lw();
        issue(5'd4, 5'd9, 5'd0, 32'h100, 32'h0, 16'h0010, 6'h00, 2'b00, 1'b1, 1'b0,
              1'b1, 1'b1);
    endtask

    // ---- stimulus ----
    initial begin
        exp_t lw_e, dep_e;
        funct_tbl[0] = 6'h20; funct_tbl[1] = 6'h22; funct_tbl[2] = 6'h24;
        funct_tbl[3] = 6'h25; funct_tbl[4] = 6'h2a;

        Reset = 1'b1; Stall_EX = 1'b0; Flush_ID = 1'b0; Valid_ID = 1'b0;
        Read_Data_1_ID = '0; Read_Data_2_ID = '0; Imm_ID = '0; Funct_ID = '0;
        Rs_ID = '0; Rt_ID = '0; Rd_ID = '0; ALUOp_ID = '0;
        ALUSrc_ID = 1'b0; RegDst_ID = 1'b0; RegWrite_ID = 1'b0; MemRead_ID = 1'b0;
        Write_Register_MEM = '0; Write_Register_WB = '0;
        RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
        ALU_Result_MEM = '0; Write_Data_WB = '0;

        #3;
        check("rst_ctrl",  {28'h0, ALU_Control_EX}, 32'h2);
        check("rst_valid", {31'h0, Valid_EX}, 32'h0);
        check("rst_rw",    {31'h0, RegWrite_EX}, 32'h0);
        check("rst_rd1",   Read_Data_1_EX, 32'h0);
        check("rst_lus",   {31'h0, Load_Use_Stall}, 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // slt $10, $1, $2
        issue(5'd1, 5'd2, 5'd10, 32'hFFFF_FFFE, 32'd5, 16'h0000, 6'h2a, 2'b10,
              1'b0, 1'b1, 1'b0, 1'b0);
        // addi $3, $1, 0x8000 (sign-extended)
        issue(5'd1, 5'd3, 5'd0, 32'h11, 32'h22, 16'h8000, 6'h00, 2'b00,
              1'b1, 1'b0, 1'b0, 1'b0);
        // ori $3, $1, 0x8000 (zero-extended)
        issue(5'd1, 5'd3, 5'd0, 32'h11, 32'h22, 16'h8000, 6'h00, 2'b11,
              1'b1, 1'b0, 1'b0, 1'b0);
        // beq-style subtract, and an unknown funct
        issue(5'd5, 5'd6, 5'd0, 32'h7, 32'h3, 16'h0004, 6'h00, 2'b01,
              1'b0, 1'b0, 1'b0, 1'b0);
        issue(5'd5, 5'd6, 5'd7, 32'h7, 32'h3, 16'h0000, 6'h3f, 2'b10,
              1'b0, 1'b1, 1'b0, 1'b0);

        // random non-writing traffic: no hazards possible
        for (int i = 0; i < 20; i++) begin
            logic [5:0] f;
            int sel;
            sel = $urandom_range(0, 5);
            f = (sel == 5) ? 6'($urandom_range(0, 63)) : funct_tbl[sel];
            issue(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                  5'($urandom_range(1, 31)), $urandom, $urandom,
                  16'($urandom_range(0, 65535)), f, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // forwarding on rs=8
        issue(5'd8, 5'd3, 5'd0, 32'hAAAA, 32'hBBBB, 16'h0000, 6'h20, 2'b10,
              1'b0, 1'b0, 1'b0, 1'b0);
        set_id(5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 16'h0, 6'h20, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        RegWrite_MEM = 1'b1; Write_Register_MEM = 5'd8; ALU_Result_MEM = 32'h1234;
        RegWrite_WB  = 1'b1; Write_Register_WB  = 5'd8; Write_Data_WB  = 32'h5678;
        #1;
        check("fwd_mem", Read_Data_1_EX, FWD ? 32'h1234 : 32'hAAAA);
        check("fwd_rt_none", Read_Data_2_EX, 32'hBBBB);
        check("fwd_nolus", {31'h0, Load_Use_Stall}, 32'h0);
        Write_Register_MEM = 5'd0;
        #1;
        check("fwd_wb", Read_Data_1_EX, FWD ? 32'h5678 : 32'hAAAA);
        // an ID reader of the MEM destination stalls only without forwarding
        Write_Register_MEM = 5'd8;
        Rs_ID = 5'd8;
        #1;
        check("mem_raw_lus", {31'h0, Load_Use_Stall}, FWD ? 32'h0 : 32'h1);
        RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
        Write_Register_MEM = '0; Write_Register_WB = '0;
        Rs_ID = 5'd1;
        #1;

        // load-use: lw $9 in EX, add $11, $3, $9 in ID
        issue_lw();
        lw_e  = model(5'd9, 5'd0, 32'h100, 32'h0, 16'h0010, 6'h00, 2'b00, 1'b1, 1'b0,
                      1'b1, 1'b1);
        set_id(5'd3, 5'd9, 5'd11, 32'h7, 32'h8, 16'h0, 6'h20, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        dep_e = model(5'd9, 5'd11, 32'h7, 32'h8, 16'h0, 6'h20, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check("lu_stall", {31'h0, Load_Use_Stall}, 32'h1);
        exp_q.push_back(bubble());
        tick_check();
        check("lu_release", {31'h0, Load_Use_Stall}, 32'h0);
        exp_q.push_back(dep_e);
        tick_check();

        // Stall_EX together with a load-use hazard: hold first, bubble after
        issue_lw();
        Stall_EX = 1'b1;
        set_id(5'd9, 5'd2, 5'd12, 32'h1, 32'h2, 16'h0, 6'h22, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        dep_e = model(5'd2, 5'd12, 32'h1, 32'h2, 16'h0, 6'h22, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("hold_lus", {31'h0, Load_Use_Stall}, 32'h1);
        exp_q.push_back(lw_e);
        tick_check();
        Stall_EX = 1'b0;
        exp_q.push_back(bubble());
        tick_check();
        exp_q.push_back(dep_e);
        tick_check();

        // Stall_EX for three cycles with changing ID inputs
        issue(5'd13, 5'd14, 5'd15, 32'hCAFE_0001, 32'hCAFE_0002, 16'h0, 6'h25, 2'b10,
              1'b0, 1'b1, 1'b0, 1'b0);
        dep_e = model(5'd14, 5'd15, 32'hCAFE_0001, 32'hCAFE_0002, 16'h0, 6'h25, 2'b10,
                      1'b0, 1'b1, 1'b0, 1'b0);
        Stall_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                   5'($urandom_range(1, 31)), $urandom, $urandom,
                   16'($urandom_range(0, 65535)), 6'h24, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
            exp_q.push_back(dep_e);
            tick_check();
        end
        Stall_EX = 1'b0;

        // Flush a writing instruction
        set_id(5'd1, 5'd2, 5'd16, 32'h5, 32'h6, 16'h0, 6'h20, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        Flush_ID = 1'b1;
        exp_q.push_back(bubble());
        tick_check();
        Flush_ID = 1'b0;

        // Flush masks a load-use hazard
        issue_lw();
        set_id(5'd9, 5'd2, 5'd17, 32'h5, 32'h6, 16'h0, 6'h20, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        Flush_ID = 1'b1;
        #1;
        check("flush_lus", {31'h0, Load_Use_Stall}, 32'h0);
        exp_q.push_back(bubble());
        tick_check();
        Flush_ID = 1'b0;

        // Reset asserted mid-stall clears before the next edge
        issue_lw();
        set_id(5'd9, 5'd2, 5'd17, 32'h5, 32'h6, 16'h0, 6'h20, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check("pre_rst_lus", {31'h0, Load_Use_Stall}, 32'h1);
        Reset = 1'b1;
        #1;
        check("mid_rst_ctrl",  {28'h0, ALU_Control_EX}, 32'h2);
        check("mid_rst_valid", {31'h0, Valid_EX}, 32'h0);
        check("mid_rst_mr",    {31'h0, MemRead_EX}, 32'h0);
        check("mid_rst_alu2",  ALU_Data_2_EX, 32'h0);
        check("mid_rst_lus",   {31'h0, Load_Use_Stall}, 32'h0);
        #2;
        Reset = 1'b0;
        Valid_ID = 1'b0;

        check("sb_leftover", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
